// File: rtl/multiword_add_sub.sv
// ---------------------------------------------------------------------------
// multiword_add_sub
//
// Sequential multi-precision adder/subtractor.  Operands wider than one word
// are streamed in least-significant word first.  The carry out of each word is
// held in a carry register and fed back into the next word of the same packet.
// The flags presented with the final word describe the full-width result.
//
// Parameters
//   DATA_WIDTH  word width (passed to the internal adder)
//   BLOCK_SIZE  lookahead block size of the internal adder; must divide
//               DATA_WIDTH
//
// Ports
//   clk, rst            clock (rising edge) and asynchronous active-high reset
//   in_valid/in_ready   input handshake; in_ready = !out_valid || out_ready
//   in_first, in_last   packet framing of the input word
//   sub                 1 = A-B, 0 = A+B (taken from the first word only)
//   A, B                operand words
//   out_valid/out_ready output handshake (single register stage)
//   out_last            result word is the most-significant word
//   S                   result word
//   CF, OF, ZF          carry (1 = no borrow), signed overflow and zero flags
//                       of the whole packet; non-zero only with out_last
//
// Configuration
//   MULTIWORD_ZERO_FLAG_EN  when defined, the zero accumulator and ZF are
//                           built; otherwise ZF is tied to 0.
// ---------------------------------------------------------------------------

// Carry lookahead adder: per-block group generate/propagate decide the carry
// into the next block, bit carries are resolved inside each block.
module carry_lookahead_adder #(
   parameter int DATA_WIDTH = 8,
   parameter int BLOCK_SIZE = 1
) (
   input  logic [DATA_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] B,
   input  logic                  Cin,
   output logic [DATA_WIDTH-1:0] S,
   output logic                  CF,
   output logic                  OF
);

   localparam int NUM_BLOCKS = DATA_WIDTH / BLOCK_SIZE;

   // All carries are kept local to this block so the carry chain is evaluated
   // in order without creating a combinational loop on a module signal.
   always_comb begin
      logic [DATA_WIDTH:0]   c;
      logic [DATA_WIDTH-1:0] g;
      logic [DATA_WIDTH-1:0] p;
      logic                  blk_g;
      logic                  blk_p;
      g     = A & B;
      p     = A ^ B;
      c     = '0;
      blk_g = 1'b0;
      blk_p = 1'b1;
      c[0]  = Cin;
      for (int k = 0; k < NUM_BLOCKS; k++) begin
         blk_g = 1'b0;
         blk_p = 1'b1;
         for (int j = 0; j < BLOCK_SIZE; j++) begin
            blk_g = g[k*BLOCK_SIZE+j] | (p[k*BLOCK_SIZE+j] & blk_g);
            blk_p = blk_p & p[k*BLOCK_SIZE+j];
         end
         for (int j = 1; j < BLOCK_SIZE; j++) begin
            c[k*BLOCK_SIZE+j] = g[k*BLOCK_SIZE+j-1]
                              | (p[k*BLOCK_SIZE+j-1] & c[k*BLOCK_SIZE+j-1]);
         end
         c[(k+1)*BLOCK_SIZE] = blk_g | (blk_p & c[k*BLOCK_SIZE]);
      end
      S  = p ^ c[DATA_WIDTH-1:0];
      CF = c[DATA_WIDTH];
      OF = c[DATA_WIDTH] ^ c[DATA_WIDTH-1];
   end

endmodule

module multiword_add_sub #(
   parameter int DATA_WIDTH = 8,
   parameter int BLOCK_SIZE = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_first,
   input  logic                  in_last,
   input  logic                  sub,
   input  logic [DATA_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] B,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic [DATA_WIDTH-1:0] S,
   output logic                  CF,
   output logic                  OF,
   output logic                  ZF
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                state;
   state_t                state_next;
   logic                  carry_q;
   logic                  sub_q;
   logic                  accept;
   logic                  first;
   logic                  op;
   logic                  cin;
   logic [DATA_WIDTH-1:0] b_eff;
   logic [DATA_WIDTH-1:0] add_s;
   logic                  add_cf;
   logic                  add_of;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // A word arriving in IDLE always opens a packet; in BUSY an explicit
   // in_first restarts the packet and the stale carry is ignored.
   assign first = (state == IDLE) || in_first;
   assign op    = first ? sub : sub_q;
   assign cin   = first ? sub : carry_q;
   assign b_eff = B ^ {DATA_WIDTH{op}};

   carry_lookahead_adder #(
      .DATA_WIDTH (DATA_WIDTH),
      .BLOCK_SIZE (BLOCK_SIZE)
   ) u_adder (
      .A   (A),
      .B   (b_eff),
      .Cin (cin),
      .S   (add_s),
      .CF  (add_cf),
      .OF  (add_of)
   );

   // Packet state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // The last word of a packet returns to IDLE, any other word leaves us
   // mid-packet.
   always_comb begin
      state_next = state;
      if (accept) begin
         state_next = in_last ? IDLE : BUSY;
      end
   end

   // Carry chaining between words and the per-packet operation latch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         carry_q <= 1'b0;
         sub_q   <= 1'b0;
      end else if (accept) begin
         carry_q <= add_cf;
         if (first) begin
            sub_q <= sub;
         end
      end
   end

   // Single output register stage; flags are only meaningful on the last
   // word, so they are forced to zero on intermediate words.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         S         <= '0;
         CF        <= 1'b0;
         OF        <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_last  <= in_last;
         S         <= add_s;
         CF        <= in_last ? add_cf : 1'b0;
         OF        <= in_last ? add_of : 1'b0;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef MULTIWORD_ZERO_FLAG_EN
   logic zacc;
   logic zacc_next;

   assign zacc_next = (add_s == '0) & (first ? 1'b1 : zacc);

   // Running "every word so far was zero" flag, reported on the last word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zacc <= 1'b0;
         ZF   <= 1'b0;
      end else if (accept) begin
         zacc <= zacc_next;
         ZF   <= in_last ? zacc_next : 1'b0;
      end
   end
`else
   assign ZF = 1'b0;
`endif

endmodule

// File: tb/tb_multiword_add_sub.sv
// ---------------------------------------------------------------------------
// tb_multiword_add_sub
//
// Directed testbench for multiword_add_sub (DATA_WIDTH=8, BLOCK_SIZE=1).
// Walks through single-word add, multi-word add/subtract, equal subtract,
// packet restart, output backpressure and asynchronous reset mid-packet.
// ---------------------------------------------------------------------------
module tb_multiword_add_sub;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic       in_first;
   logic       in_last;
   logic       sub;
   logic [7:0] A;
   logic [7:0] B;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;
   logic [7:0] S;
   logic       CF;
   logic       OF;
   logic       ZF;

   int testsRun;
   int testsFailed;

`ifdef MULTIWORD_ZERO_FLAG_EN
   localparam logic ZF_EQUAL = 1'b1;
`else
   localparam logic ZF_EQUAL = 1'b0;
`endif

   multiword_add_sub #(
      .DATA_WIDTH (8),
      .BLOCK_SIZE (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_first  (in_first),
      .in_last   (in_last),
      .sub       (sub),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .S         (S),
      .CF        (CF),
      .OF        (OF),
      .ZF        (ZF)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: counts it, and on mismatch counts and reports the failure.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         testsFailed++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drives one word from a falling edge and holds it until it is accepted on
   // a rising edge; returns 1 ns after that edge with in_valid dropped.
   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                input logic f, input logic l, input logic s);
      bit accepted;
      accepted = 0;
      @(negedge clk);
      A        = a;
      B        = b;
      in_first = f;
      in_last  = l;
      sub      = s;
      in_valid = 1'b1;
      for (int i = 0; i < 20 && !accepted; i++) begin
         #1;
         if (in_ready) begin
            @(posedge clk);
            accepted = 1;
         end else begin
            @(negedge clk);
         end
      end
      if (!accepted) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL accept_timeout observed=0 expected=1");
      end
      #1;
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      rst         = 1'b1;
      in_valid    = 1'b0;
      in_first    = 1'b0;
      in_last     = 1'b0;
      sub         = 1'b0;
      A           = '0;
      B           = '0;
      out_ready   = 1'b1;

      // Reset state.
      #3;
      checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
      checkOutput("rst_out_last",  32'(out_last),  32'h0);
      checkOutput("rst_S",         32'(S),         32'h0);
      checkOutput("rst_CF",        32'(CF),        32'h0);
      checkOutput("rst_OF",        32'(OF),        32'h0);
      checkOutput("rst_ZF",        32'(ZF),        32'h0);
      checkOutput("rst_in_ready",  32'(in_ready),  32'h1);
      @(negedge clk);
      rst = 1'b0;

      // Single word 0x7F + 0x01 = 0x80, signed overflow.
      applyStimulus(8'h7F, 8'h01, 1'b1, 1'b1, 1'b0);
      checkOutput("w1_out_valid", 32'(out_valid), 32'h1);
      checkOutput("w1_S",         32'(S),         32'h80);
      checkOutput("w1_CF",        32'(CF),        32'h0);
      checkOutput("w1_OF",        32'(OF),        32'h1);
      checkOutput("w1_ZF",        32'(ZF),        32'h0);
      checkOutput("w1_out_last",  32'(out_last),  32'h1);

      // 0x01FF + 0x0001 = 0x0200.
      applyStimulus(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
      checkOutput("add2_w0_S",    32'(S),        32'h00);
      checkOutput("add2_w0_last", 32'(out_last), 32'h0);
      checkOutput("add2_w0_CF",   32'(CF),       32'h0);
      applyStimulus(8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
      checkOutput("add2_w1_S",    32'(S),        32'h02);
      checkOutput("add2_w1_CF",   32'(CF),       32'h0);
      checkOutput("add2_w1_OF",   32'(OF),       32'h0);
      checkOutput("add2_w1_ZF",   32'(ZF),       32'h0);
      checkOutput("add2_w1_last", 32'(out_last), 32'h1);

      // 0x0100 - 0x0001 = 0x00FF; sub deasserted on word 1 must be ignored.
      applyStimulus(8'h00, 8'h01, 1'b1, 1'b0, 1'b1);
      checkOutput("sub2_w0_S", 32'(S), 32'hFF);
      applyStimulus(8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
      checkOutput("sub2_w1_S",    32'(S),        32'h00);
      checkOutput("sub2_w1_CF",   32'(CF),       32'h1);
      checkOutput("sub2_w1_OF",   32'(OF),       32'h0);
      checkOutput("sub2_w1_ZF",   32'(ZF),       32'h0);
      checkOutput("sub2_w1_last", 32'(out_last), 32'h1);

      // 0x1234 - 0x1234 = 0 with no borrow.
      applyStimulus(8'h34, 8'h34, 1'b1, 1'b0, 1'b1);
      checkOutput("eq_w0_S",  32'(S),  32'h00);
      checkOutput("eq_w0_ZF", 32'(ZF), 32'h0);
      applyStimulus(8'h12, 8'h12, 1'b0, 1'b1, 1'b1);
      checkOutput("eq_w1_S",  32'(S),  32'h00);
      checkOutput("eq_w1_CF", 32'(CF), 32'h1);
      checkOutput("eq_w1_OF", 32'(OF), 32'h0);
      checkOutput("eq_w1_ZF", 32'(ZF), 32'(ZF_EQUAL));

      // in_first mid-packet restarts: carry from 0xFF+0x01 must be dropped.
      applyStimulus(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
      applyStimulus(8'h05, 8'h01, 1'b1, 1'b1, 1'b0);
      checkOutput("restart_S",  32'(S),  32'h06);
      checkOutput("restart_CF", 32'(CF), 32'h0);

      // Backpressure: let the output drain, then stall the consumer.
      @(negedge clk);
      @(negedge clk);
      checkOutput("drain_out_valid", 32'(out_valid), 32'h0);
      out_ready = 1'b0;
      applyStimulus(8'h10, 8'h20, 1'b1, 1'b1, 1'b0);
      checkOutput("bp_w1_S", 32'(S), 32'h30);
      @(negedge clk);
      A        = 8'h01;
      B        = 8'h02;
      in_first = 1'b1;
      in_last  = 1'b1;
      sub      = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checkOutput("bp_in_ready",  32'(in_ready),  32'h0);
         checkOutput("bp_S_hold",    32'(S),         32'h30);
         checkOutput("bp_valid_hold", 32'(out_valid), 32'h1);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
      checkOutput("bp_w2_valid", 32'(out_valid), 32'h1);
      checkOutput("bp_w2_S",     32'(S),         32'h03);
      @(posedge clk);
      #1;
      checkOutput("bp_no_dup", 32'(out_valid), 32'h0);

      // Asynchronous reset after word 0 of a two-word add.
      applyStimulus(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
      checkOutput("mid_w0_valid", 32'(out_valid), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_valid",    32'(out_valid), 32'h0);
      checkOutput("mid_rst_in_ready", 32'(in_ready),  32'h1);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(8'h01, 8'h01, 1'b0, 1'b1, 1'b0);
      checkOutput("mid_new_S",    32'(S),        32'h02);
      checkOutput("mid_new_CF",   32'(CF),       32'h0);
      checkOutput("mid_new_last", 32'(out_last), 32'h1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/multiword_add_sub.md
# multiword_add_sub

Sequential multi-precision adder/subtractor that streams operands wider than `DATA_WIDTH` one word at a time, least-significant word first. It sits directly around a `carry_lookahead_adder` instance:
- Upstream, it drives the adder's A, B and Cin.
- Downstream, it registers the adder's S, CF and OF.
- It carries CF from word to word through an internal carry register.

Final-word flags describe the full-width result.

## Interface
Parameters:
- `DATA_WIDTH`, 8: word width; passed to the internal adder.
- `BLOCK_SIZE`, 1: lookahead block size of the internal adder; must divide `DATA_WIDTH`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  operand word present.
- `in_ready`  out  1  block can accept a word this cycle.
- `in_first`  in  1  word is the least-significant word of a packet.
- `in_last`  in  1  word is the most-significant word of a packet.
- `sub`  in  1  1 = A−B, 0 = A+B; sampled on the first word only.
- `A`  in  `DATA_WIDTH`  minuend/augend word.
- `B`  in  `DATA_WIDTH`  subtrahend/addend word.
- `out_valid`  out  1  result word present.
- `out_ready`  in  1  consumer accepts result word.
- `out_last`  out  1  result word is the packet's most-significant word.
- `S`  out  `DATA_WIDTH`  result word.
- `CF`  out  1  carry out of the packet (1 = no borrow when subtracting); valid with `out_last`.
- `OF`  out  1  signed overflow of the packet; valid with `out_last`.
- `ZF`  out  1  all result words of the packet are zero; valid with `out_last`.

## Operation
- A word is accepted when `in_valid && in_ready`.
- `in_ready = !out_valid || out_ready` (combinational). The output register is a single stage.
- State machine:
  - IDLE: expecting a first word.
  - BUSY: mid-packet.
  - An accepted word with `in_last` moves the block to IDLE.
  - Any other accepted word moves it to BUSY.
- First-word handling:
  - A word accepted in IDLE is always treated as a first word, whether or not `in_first` is asserted.
  - A word accepted in BUSY with `in_first` asserted restarts the packet and discards the carry register.
- On a first word:
  - `sub` is latched into `sub_q`.
  - Adder Cin = `sub`.
- On later words:
  - Adder Cin = carry register.
  - The operation uses `sub_q`.
- Adder B input = `B ^ {DATA_WIDTH{op}}`, where op is `sub` or `sub_q` as selected above. A is passed unmodified.
- On every accepted word:
  - The carry register loads the adder's CF.
  - The zero accumulator loads `(S==0) & (first ? 1 : zacc)`.
- The output register loads S, `out_last = in_last`, and `out_valid = 1`.
  - If the word is last: CF, OF and ZF load the adder CF, the adder OF, and the final zero accumulation.
  - Otherwise: CF, OF and ZF load 0.
- `out_valid` clears on `out_ready` when no new word is accepted the same cycle.

## Timing
- Latency is one cycle: a word accepted at edge n appears on S at edge n (registered output, visible in cycle n+1).
- Throughput is one word per cycle while `out_ready` is held high.
- Simultaneous output drain and input accept in the same cycle is required behaviour and produces no bubble.
- When `out_valid && !out_ready`, all outputs hold stable.
- Reset, while `rst` is asserted, takes effect immediately:
  - State = IDLE; carry register, zero accumulator and `sub_q` = 0.
  - `out_valid`, `out_last`, S, CF, OF and ZF = 0.
  - `in_ready` = 1.
- Reset mid-packet drops the partial packet. The next word starts a new packet.

## Configuration
- `MULTIWORD_ZERO_FLAG_EN` defined: the zero accumulator and ZF are implemented as above.
- `MULTIWORD_ZERO_FLAG_EN` undefined: the zero accumulator is not synthesized and ZF is tied to 0.

## Test plan
All scenarios use `DATA_WIDTH=8`, `BLOCK_SIZE=1`.
- Single-word add: A=0x7F, B=0x01, `first`=`last`=1, `sub`=0 -> S=0x80, CF=0, OF=1, ZF=0, `out_last`=1, one cycle later.
- Two-word add 0x01FF+0x0001:
  - Words (A,B) = (FF,01), (01,00).
  - Result: S=0x00 then 0x02; CF=0, OF=0, ZF=0; `out_last` on the second word only.
- Two-word subtract 0x0100−0x0001:
  - Words (A,B) = (00,01), (01,00).
  - Result: S=0xFF then 0x00; CF=1, OF=0, ZF=0.
- Equal subtract 0x1234−0x1234 -> S=0x00, 0x00; CF=1, ZF=1 (ZF=0 with the macro undefined).
- Backpressure: hold `out_ready`=0 for 3 cycles with `in_valid`=1 -> `in_ready`=0 and S stable; on release, no word is lost or duplicated.
- Reset mid-packet:
  - Stimulus: assert `rst` asynchronously after word 0 of a two-word add; `out_valid` drops immediately.
  - Next word sent without `in_first`: A=0x01, B=0x01, `last` -> S=0x02, CF=0, i.e. it is treated as a first word with Cin=0.
